slot_stream_relay: RTL and testbench

//  Inter-slot stream relay on the output stream of the Mmap2Stream_0 task in SLOT_X0Y2.

---
 rtl/slot_stream_relay.sv | 163 ++++++++++++++++
 tb/tb_slot_stream_relay.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/slot_stream_relay.sv
// slot_stream_relay: registered relay carrying one TAPA stream across a slot boundary.
// Forward data pipe, backward full_n pipe, first-word-fall-through FIFO with almost-full grace.
module slot_stream_relay #(
   parameter int DATA_WIDTH = 65,
   parameter int PIPE_LEVEL = 2,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 4
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic [DATA_WIDTH-1:0] in_din,
   input  logic                  in_write,
   output logic                  in_full_n,
   output logic [DATA_WIDTH-1:0] out_dout,
   output logic                  out_empty_n,
   input  logic                  out_read,
   output logic [CNT_W-1:0]      occupancy,
   output logic                  overflow_err
);

   localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int FLT_W  = 3;
   localparam int SUM_W  = CNT_W + 3;
   localparam int THRESH = DEPTH - (2 * PIPE_LEVEL + 2);

   if ((PIPE_LEVEL < 0) || (PIPE_LEVEL > 4)) begin : g_bad_pipe
      $error("slot_stream_relay: PIPE_LEVEL must be within 0..4");
   end
   if (DEPTH < (2 * PIPE_LEVEL + 2)) begin : g_bad_depth
      $error("slot_stream_relay: DEPTH must be at least 2*PIPE_LEVEL+2");
   end
   if (CNT_W != $clog2(DEPTH + 1)) begin : g_bad_cnt
      $error("slot_stream_relay: CNT_W must equal clog2(DEPTH+1)");
   end

   logic                  arr_vld_s;
   logic [DATA_WIDTH-1:0] arr_dat_s;
   logic [FLT_W-1:0]      inflight_next_s;
   logic                  full_i_r;
   logic                  full_i_next_s;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0]      wr_ptr_r;
   logic [PTR_W-1:0]      rd_ptr_r;
   logic [PTR_W-1:0]      wr_ptr_next_s;
   logic [PTR_W-1:0]      rd_ptr_next_s;
   logic [CNT_W-1:0]      occ_r;
   logic [CNT_W-1:0]      occ_next_s;
   logic [SUM_W-1:0]      sum_s;
   logic                  empty_n_r;
   logic                  ovf_r;
   logic [DATA_WIDTH-1:0] dout_r;
   logic [DATA_WIDTH-1:0] dout_next_s;
   logic                  pop_s;
   logic                  store_s;
   logic                  drop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_W'(DEPTH - 1)) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   if (PIPE_LEVEL == 0) begin : g_direct
      assign arr_vld_s       = in_write;
      assign arr_dat_s       = in_din;
      assign inflight_next_s = '0;
      assign in_full_n       = full_i_r;
   end else begin : g_pipe
      logic [PIPE_LEVEL-1:0]                 vld_r;
      logic [PIPE_LEVEL-1:0][DATA_WIDTH-1:0] dat_r;
      logic [PIPE_LEVEL-1:0]                 fn_r;
      logic [PIPE_LEVEL:0]                   vld_chain_s;
      logic [PIPE_LEVEL:0][DATA_WIDTH-1:0]   dat_chain_s;
      logic [PIPE_LEVEL:0]                   fn_chain_s;

      assign vld_chain_s = {vld_r, in_write};
      assign dat_chain_s = {dat_r, in_din};
      assign fn_chain_s  = {fn_r, full_i_r};

      // forward word stages and backward full_n stages shift every cycle, never stall
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            vld_r <= '0;
            dat_r <= '0;
            fn_r  <= '0;
         end else begin
            vld_r <= vld_chain_s[PIPE_LEVEL-1:0];
            dat_r <= dat_chain_s[PIPE_LEVEL-1:0];
            fn_r  <= fn_chain_s[PIPE_LEVEL-1:0];
         end
      end

      // words that will sit in the forward stages once this edge has shifted them
      always_comb begin
         inflight_next_s = '0;
         for (int k = 0; k < PIPE_LEVEL; k++) begin
            inflight_next_s = inflight_next_s + FLT_W'(vld_chain_s[k]);
         end
      end

      assign arr_vld_s = vld_chain_s[PIPE_LEVEL];
      assign arr_dat_s = dat_chain_s[PIPE_LEVEL];
      assign in_full_n = fn_chain_s[PIPE_LEVEL];
   end

   // FIFO next-state: a pop needs a visible head, so a read against an empty FIFO is ignored
   always_comb begin
      pop_s         = out_read & empty_n_r;
      store_s       = arr_vld_s & ((occ_r != CNT_W'(DEPTH)) | pop_s);
      drop_s        = arr_vld_s & ~store_s;
      rd_ptr_next_s = pop_s   ? ptr_inc(rd_ptr_r) : rd_ptr_r;
      wr_ptr_next_s = store_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
      occ_next_s    = occ_r + CNT_W'(store_s) - CNT_W'(pop_s);
      sum_s         = SUM_W'(occ_next_s) + SUM_W'(inflight_next_s);
      full_i_next_s = (sum_s <= SUM_W'(THRESH));
      if (occ_next_s == '0) begin
         dout_next_s = '0;
      end else if (store_s && (wr_ptr_r == rd_ptr_next_s)) begin
         dout_next_s = arr_dat_s;
      end else begin
         dout_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // FIFO control state, grace-threshold flag and registered read-side outputs
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         occ_r     <= '0;
         empty_n_r <= 1'b0;
         dout_r    <= '0;
         ovf_r     <= 1'b0;
         full_i_r  <= 1'b0;
      end else begin
         wr_ptr_r  <= wr_ptr_next_s;
         rd_ptr_r  <= rd_ptr_next_s;
         occ_r     <= occ_next_s;
         empty_n_r <= (occ_next_s != '0);
         dout_r    <= dout_next_s;
         ovf_r     <= ovf_r | drop_s;
         full_i_r  <= full_i_next_s;
      end
   end

   // storage array, written only when an arriving word is accepted
   always_ff @(posedge ap_clk) begin
      if (store_s) begin
         mem_r[wr_ptr_r] <= arr_dat_s;
      end
   end

   assign out_dout     = dout_r;
   assign out_empty_n  = empty_n_r;
   assign occupancy    = occ_r;
   assign overflow_err = ovf_r;

endmodule

// File: tb/tb_slot_stream_relay.sv
// Scoreboard bench for slot_stream_relay: stimulus pushes expected words,
// a negedge monitor pops and compares every word the DUT hands out.
module tb_slot_stream_relay;
   localparam int DW    = 65;
   localparam int DEPTH = 8;

   logic          ap_clk = 1'b0;
   logic          ap_rst;
   logic [DW-1:0] in_din;
   logic          in_write;
   logic          in_full_n;
   logic [DW-1:0] out_dout;
   logic          out_empty_n;
   logic          out_read;
   logic [3:0]    occupancy;
   logic          overflow_err;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] sb_q[$];
   logic [DW-1:0] mon_exp;
   int            sent;
   int            peak;

   always #5 ap_clk = ~ap_clk;

   slot_stream_relay #(.DATA_WIDTH(65), .PIPE_LEVEL(2), .DEPTH(8), .CNT_W(4)) dut (
      .ap_clk      (ap_clk),
      .ap_rst      (ap_rst),
      .in_din      (in_din),
      .in_write    (in_write),
      .in_full_n   (in_full_n),
      .out_dout    (out_dout),
      .out_empty_n (out_empty_n),
      .out_read    (out_read),
      .occupancy   (occupancy),
      .overflow_err(overflow_err)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic wait_full_n();
      for (int k = 0; k < 20 && !in_full_n; k++) step();
      check("wait_full_n", 128'(in_full_n), 128'd1);
   endtask

   function automatic logic [DW-1:0] mk_word(input int tag, input int i);
      logic [31:0] iv;
      iv = 32'(i);
      return {iv[0], 32'(tag), iv};
   endfunction

   // monitor: a word leaves when out_read meets out_empty_n at the coming edge
   always @(negedge ap_clk) begin
      if (!ap_rst && out_read && out_empty_n) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%0h required=none", out_dout);
         end else begin
            mon_exp = sb_q.pop_front();
            check("pop_order", 128'(out_dout), 128'(mon_exp));
         end
      end
   end

   initial begin
      ap_rst   = 1'b1;
      in_din   = '0;
      in_write = 1'b0;
      out_read = 1'b0;
      repeat (3) step();
      check("rst_full_n",  128'(in_full_n),    128'd0);
      check("rst_empty_n", 128'(out_empty_n),  128'd0);
      check("rst_dout",    128'(out_dout),     128'd0);
      check("rst_occ",     128'(occupancy),    128'd0);
      check("rst_ovf",     128'(overflow_err), 128'd0);

      // full_n comes back PIPE_LEVEL+1 edges after release
      ap_rst = 1'b0;
      step(); check("rise_0", 128'(in_full_n), 128'd0);
      step(); check("rise_1", 128'(in_full_n), 128'd0);
      step(); check("rise_2", 128'(in_full_n), 128'd1);

      // test 1: latency of a single word
      in_write = 1'b1;
      in_din   = 65'h1_DEADBEEF_00000001;
      sb_q.push_back(65'h1_DEADBEEF_00000001);
      step();
      in_write = 1'b0;
      step(); check("lat_empty_t2", 128'(out_empty_n), 128'd0);
      step(); check("lat_empty_t3", 128'(out_empty_n), 128'd1);
      check("lat_dout", 128'(out_dout), 128'h1_DEADBEEF_00000001);
      check("lat_occ",  128'(occupancy), 128'd1);
      out_read = 1'b1;
      step();
      out_read = 1'b0;
      check("lat_drained", 128'(out_empty_n), 128'd0);

      // test 2: compliant producer, no reads; threshold admits exactly 5 words
      wait_full_n();
      sent = 0;
      peak = 0;
      for (int c = 0; c < 30; c++) begin
         if (in_full_n && sent < 20) begin
            in_write = 1'b1;
            in_din   = mk_word(2, sent);
            sb_q.push_back(mk_word(2, sent));
            sent++;
         end else begin
            in_write = 1'b0;
         end
         step();
         if (int'(occupancy) > peak) peak = int'(occupancy);
      end
      in_write = 1'b0;
      check("fill_accepted", 128'(sent), 128'd5);
      check("fill_peak_ok",  128'(peak <= DEPTH), 128'd1);
      check("fill_occ",      128'(occupancy), 128'd5);
      check("fill_ovf",      128'(overflow_err), 128'd0);
      check("fill_full_n",   128'(in_full_n), 128'd0);

      // test 3: drain; full_n returns two edges after occupancy falls to the threshold
      out_read = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         step();
         if (i == 4) check("drain_full_n_4", 128'(in_full_n), 128'd0);
         if (i == 5) check("drain_full_n_5", 128'(in_full_n), 128'd1);
      end
      out_read = 1'b0;
      check("drain_empty", 128'(out_empty_n), 128'd0);
      check("drain_sb",    128'(sb_q.size()), 128'd0);

      // test 4: streaming read+write each cycle, occupancy holds at 1
      wait_full_n();
      out_read = 1'b1;
      for (int i = 0; i < 100; i++) begin
         in_write = 1'b1;
         in_din   = mk_word(4, i);
         sb_q.push_back(mk_word(4, i));
         step();
         if (i >= 2) check("stream_occ", 128'(occupancy), 128'd1);
      end
      in_write = 1'b0;
      repeat (6) step();
      out_read = 1'b0;
      check("stream_ovf",   128'(overflow_err), 128'd0);
      check("stream_sb",    128'(sb_q.size()), 128'd0);
      check("stream_empty", 128'(out_empty_n), 128'd0);

      // test 5: 12 forced writes, no reads; words 8..11 are dropped
      wait_full_n();
      for (int i = 0; i < 12; i++) begin
         in_write = 1'b1;
         in_din   = mk_word(5, i);
         if (i < DEPTH) sb_q.push_back(mk_word(5, i));
         step();
      end
      in_write = 1'b0;
      repeat (4) step();
      check("ovf_flag",   128'(overflow_err), 128'd1);
      check("ovf_occ",    128'(occupancy), 128'd8);
      check("ovf_full_n", 128'(in_full_n), 128'd0);
      out_read = 1'b1;
      repeat (12) step();
      out_read = 1'b0;
      check("ovf_empty", 128'(out_empty_n), 128'd0);
      check("ovf_sb",    128'(sb_q.size()), 128'd0);

      // test 6: reset with 5 buffered and 2 in flight
      wait_full_n();
      for (int i = 0; i < 7; i++) begin
         in_write = 1'b1;
         in_din   = mk_word(6, i);
         step();
      end
      in_write = 1'b0;
      check("pre_rst_occ", 128'(occupancy), 128'd5);
      ap_rst = 1'b1;
      step();
      check("mid_rst_empty", 128'(out_empty_n),  128'd0);
      check("mid_rst_occ",   128'(occupancy),    128'd0);
      check("mid_rst_ovf",   128'(overflow_err), 128'd0);
      check("mid_rst_fulln", 128'(in_full_n),    128'd0);
      check("mid_rst_dout",  128'(out_dout),     128'd0);
      ap_rst = 1'b0;
      sb_q.delete();
      out_read = 1'b1;
      step(); check("rerise_0", 128'(in_full_n), 128'd0);
      step(); check("rerise_1", 128'(in_full_n), 128'd0);
      step(); check("rerise_2", 128'(in_full_n), 128'd1);
      repeat (8) step();
      check("no_stale", 128'(out_empty_n), 128'd0);

      // one fresh word after reset must come out, not a stale one
      in_write = 1'b1;
      in_din   = mk_word(7, 0);
      sb_q.push_back(mk_word(7, 0));
      step();
      in_write = 1'b0;
      repeat (5) step();
      out_read = 1'b0;
      check("fresh_sb",    128'(sb_q.size()), 128'd0);
      check("fresh_empty", 128'(out_empty_n), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
